ex_mem_stage: RTL and testbench

Parametrised EX/MEM pipeline stage register with valid/ready handshake, synchronous flush and a forwarding tap. It sits between the execute stage (ALU) and the data-memory stage, and carries the ALU result, store data, destination register and MEM/WB control bundle. It adds back-pressure, bubble tracking and a stall-cycle counter.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/sat_counter.sv | 23 ++
 rtl/ex_mem_stage.sv | 153 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types: control bundle, held entry and the x0 register index.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned ALUOP_W_DEF    = 6;

  localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                   regwrite;
    logic                   memwrite;
    logic                   memread;
    logic                   memtoreg;
    logic [ALUOP_W_DEF-1:0] alu_op;
  } exmem_ctrl_t;

  typedef struct packed {
    exmem_ctrl_t                ctrl;
    logic [DATA_W_DEF-1:0]      alu_result;
    logic [DATA_W_DEF-1:0]      read_data2;
    logic [REG_ADDR_W_DEF-1:0]  regdst;
  } exmem_entry_t;

  // Writes to x0 are architecturally discarded, so they must never be forwarded.
  function automatic logic fwd_eligible(input logic valid, input exmem_ctrl_t ctrl,
                                        input logic [REG_ADDR_W_DEF-1:0] regdst);
    return valid & ctrl.regwrite & (regdst != REG_ZERO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, forwarding tap and stall counter.
// Define EX_MEM_SKID_EN for a 2-entry skid buffer with a registered in_ready path.
module ex_mem_stage
  import pipe_pkg::*;
#(
  // Data/index widths are stored in pipe_pkg structs and must match the package defaults.
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned ALUOP_W     = ALUOP_W_DEF,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [DATA_W-1:0]      read_data2,
  input  logic [REG_ADDR_W-1:0]  regdst,
  input  logic                   regwrite,
  input  logic                   memwrite,
  input  logic                   memread,
  input  logic                   memtoreg,
  input  logic [ALUOP_W-1:0]     alu_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      alu_result_out,
  output logic [DATA_W-1:0]      read_data2_out,
  output logic [REG_ADDR_W-1:0]  regdst_out,
  output logic                   regwrite_out,
  output logic                   memwrite_out,
  output logic                   memread_out,
  output logic                   memtoreg_out,
  output logic [ALUOP_W-1:0]     alu_op_out,
  output logic                   fwd_valid,
  output logic [REG_ADDR_W-1:0]  fwd_regdst,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  exmem_entry_t in_entry;
  exmem_entry_t main_q, main_d;
  logic         main_valid_q, main_valid_d;
  logic         accept, rel;

  always_comb begin
    in_entry               = '0;
    in_entry.ctrl.regwrite = regwrite;
    in_entry.ctrl.memwrite = memwrite;
    in_entry.ctrl.memread  = memread;
    in_entry.ctrl.memtoreg = memtoreg;
    in_entry.ctrl.alu_op   = alu_op;
    in_entry.alu_result    = alu_result;
    in_entry.read_data2    = read_data2;
    in_entry.regdst        = regdst;
  end

  assign accept = in_valid & in_ready;
  assign rel    = main_valid_q & out_ready;

`ifdef EX_MEM_SKID_EN
  exmem_entry_t skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;

  // Only registered state gates in_ready; out_ready never reaches it.
  assign in_ready = reset & ~flush & ~skid_valid_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || rel) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = reset & ~flush & (~main_valid_q | out_ready);

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end else if (rel) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
    end
  end

  // Controls are masked so a stale entry can never write memory or the register file.
  assign out_valid      = main_valid_q;
  assign alu_result_out = main_q.alu_result;
  assign read_data2_out = main_q.read_data2;
  assign regdst_out     = main_q.regdst;
  assign alu_op_out     = main_q.ctrl.alu_op;
  assign regwrite_out   = main_valid_q & main_q.ctrl.regwrite;
  assign memwrite_out   = main_valid_q & main_q.ctrl.memwrite;
  assign memread_out    = main_valid_q & main_q.ctrl.memread;
  assign memtoreg_out   = main_valid_q & main_q.ctrl.memtoreg;

  assign fwd_valid  = fwd_eligible(main_valid_q, main_q.ctrl, main_q.regdst);
  assign fwd_regdst = main_q.regdst;
  assign fwd_data   = main_q.alu_result;

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (main_valid_q & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: accepted inputs are queued, released outputs popped and checked.
module tb_ex_mem_stage;

  localparam int unsigned SCW = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] alu_result, read_data2, alu_result_out, read_data2_out, fwd_data;
  logic [4:0]  regdst, regdst_out, fwd_regdst;
  logic        regwrite, memwrite, memread, memtoreg;
  logic        regwrite_out, memwrite_out, memread_out, memtoreg_out, fwd_valid;
  logic [5:0]  alu_op, alu_op_out;
  logic [SCW-1:0] stall_cnt;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic [5:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rel    = 0;
  logic ready_toggle = 1'b0;

  always #5 clk = ~clk;

  ex_mem_stage #(
    .STALL_CNT_W(SCW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_result    (alu_result),
    .read_data2    (read_data2),
    .regdst        (regdst),
    .regwrite      (regwrite),
    .memwrite      (memwrite),
    .memread       (memread),
    .memtoreg      (memtoreg),
    .alu_op        (alu_op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result_out(alu_result_out),
    .read_data2_out(read_data2_out),
    .regdst_out    (regdst_out),
    .regwrite_out  (regwrite_out),
    .memwrite_out  (memwrite_out),
    .memread_out   (memread_out),
    .memtoreg_out  (memtoreg_out),
    .alu_op_out    (alu_op_out),
    .fwd_valid     (fwd_valid),
    .fwd_regdst    (fwd_regdst),
    .fwd_data      (fwd_data),
    .stall_cnt     (stall_cnt)
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pop on release, push on accept, drop everything on flush.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(alu_result_out), 64'hffff_ffff_ffff_ffff);
      end else begin
        e = exp_q.pop_front();
        n_rel++;
        check("out_alu", 64'(alu_result_out), 64'(e.alu));
        check("out_rd2", 64'(read_data2_out), 64'(e.rd2));
        check("out_regdst", 64'(regdst_out), 64'(e.rd));
        check("out_ctl", 64'({regwrite_out, memwrite_out, memread_out, memtoreg_out}),
              64'(e.ctl));
        check("out_op", 64'(alu_op_out), 64'(e.op));
        check("fwd_valid", 64'(fwd_valid), 64'(e.ctl[3] && (e.rd != 5'd0)));
        check("fwd_data", 64'(fwd_data), 64'(e.alu));
      end
    end
    if (flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back('{alu: alu_result, rd2: read_data2, rd: regdst,
                        ctl: {regwrite, memwrite, memread, memtoreg}, op: alu_op});
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_toggle) out_ready = ~out_ready;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_data", 64'({alu_result_out, regdst_out, alu_op_out}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    cyc();
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] d2, input logic [4:0] rd,
                        input logic [3:0] ctl, input logic [5:0] op);
    alu_result = a;
    read_data2 = d2;
    regdst = rd;
    {regwrite, memwrite, memread, memtoreg} = ctl;
    alu_op = op;
  endtask

  // Holds in_valid until the handshake is seen; returns just after the accepting edge.
  task automatic wait_accept();
    bit done = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      cyc();
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d2, input logic [4:0] rd,
                      input logic [3:0] ctl, input logic [5:0] op);
    set_in(a, d2, rd, ctl, op);
    wait_accept();
  endtask

  task automatic drain();
    bit done = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      if (exp_q.size() == 0 && !out_valid) done = 1;
      else cyc();
    end
    if (!done) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int rel0;
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_in(32'd0, 32'd0, 5'd0, 4'd0, 6'd0);

    // Single pass-through with forwarding.
    do_reset();
    out_ready = 1'b1;
    send(32'h0000_1234, 32'h0, 5'd5, 4'b1000, 6'd1);
    @(negedge clk);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_alu", 64'(alu_result_out), 64'h1234);
    check("t1_fwd_valid", 64'(fwd_valid), 64'd1);
    check("t1_fwd_regdst", 64'(fwd_regdst), 64'd5);
    cyc();
    drain();

    // Four stall cycles; second instruction waits (base) or lands in skid.
    do_reset();
    out_ready = 1'b0;
    send(32'hA0, 32'h1A, 5'd3, 4'b1010, 6'd2);
    set_in(32'hB0, 32'h1B, 5'd4, 4'b1001, 6'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef EX_MEM_SKID_EN
      check("stall_in_ready", 64'(in_ready), 64'(i == 0));
`else
      check("stall_in_ready", 64'(in_ready), 64'd0);
`endif
      check("stall_hold_alu", 64'(alu_result_out), 64'hA0);
      check("stall_hold_valid", 64'(out_valid), 64'd1);
      cyc();
`ifdef EX_MEM_SKID_EN
      in_valid = 1'b0;
`endif
    end
    check("stall_cnt_4", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
`ifndef EX_MEM_SKID_EN
    wait_accept();
`endif
    drain();

    // x0 destination must not forward.
    do_reset();
    out_ready = 1'b0;
    send(32'h55, 32'h0, 5'd0, 4'b1000, 6'd4);
    @(negedge clk);
    check("x0_fwd_valid", 64'(fwd_valid), 64'd0);
    check("x0_regwrite_out", 64'(regwrite_out), 64'd1);
    cyc();
    drain();

    // Flush kills the held store and the incoming instruction.
    do_reset();
    out_ready = 1'b0;
    send(32'hC0, 32'hDEAD, 5'd7, 4'b0100, 6'd5);
    cyc();
    cyc();
    check("fl_pre_stall", 64'(stall_cnt), 64'd2);
    check("fl_pre_memwrite", 64'(memwrite_out), 64'd1);
    set_in(32'hD0, 32'h0, 5'd8, 4'b1000, 6'd6);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_memwrite_out", 64'(memwrite_out), 64'd0);
    check("fl_stall", 64'(stall_cnt), 64'd2);
    repeat (3) cyc();
    check("fl_dropped", 64'(out_valid), 64'd0);
    check("fl_stall_later", 64'(stall_cnt), 64'd2);

    // Stream of 8 with out_ready toggling 1,0,1,0.
    do_reset();
    rel0 = n_rel;
    out_ready = 1'b1;
    @(negedge clk);
    ready_toggle = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) send(32'(i), 32'(100 + i), 5'(i + 1), 4'b1000, 6'(i));
    @(negedge clk);
    ready_toggle = 1'b0;
    cyc();
    drain();
    check("stream_count", 64'(n_rel - rel0), 64'd8);

    // Saturation then asynchronous reset mid-stall.
    do_reset();
    out_ready = 1'b0;
    send(32'hE0, 32'h0, 5'd9, 4'b0110, 6'd7);
    repeat (20) cyc();
    check("sat_15", 64'(stall_cnt), 64'd15);
    repeat (2) cyc();
    check("sat_hold", 64'(stall_cnt), 64'd15);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_stall", 64'(stall_cnt), 64'd0);
    check("mid_rst_data", 64'(alu_result_out), 64'd0);
    check("mid_rst_ctl", 64'({regwrite_out, memwrite_out, memread_out}), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    cyc();
    reset = 1'b1;
    cyc();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
